// File: rtl/inv_mac1d_pkg.sv
// inv_mac1d_pkg
// Shared definitions for the inverse-MAC solver (inv_mac1d) and its
// serial divider.
//   state_t : controller state encoding, also driven out of inv_mac1d
//             on its "state" debug port.
//   fp_max  : constant function used to derive fixed-point widths.
package inv_mac1d_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int fp_max(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/udiv_serial.sv
// udiv_serial
// Unsigned bit-serial restoring divider. It produces one quotient bit per
// clock, MSB first, and truncates toward zero.
// Ports:
//   clk      : clock
//   rst_n    : synchronous active-low reset
//   start    : load dividend/divisor; iterations run on the next NW edges
//   dividend : NW-bit unsigned dividend
//   divisor  : DW-bit unsigned divisor (caller guarantees non-zero)
//   busy     : high while iterations are pending
//   done     : one-cycle pulse after the final iteration edge
//   quotient : NW-bit quotient, valid while done is high and held afterwards
module udiv_serial #(
   parameter int NW = 21,
   parameter int DW = 13
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [NW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic          busy,
   output logic          done,
   output logic [NW-1:0] quotient
);

   localparam int CW = $clog2(NW + 1);

   // quo_q starts out holding the dividend. Each iteration shifts one
   // dividend bit out of the top and one quotient bit in at the bottom.
   logic [NW-1:0] quo_q;
   logic [DW-1:0] rem_q;
   logic [DW-1:0] dsr_q;
   logic [CW-1:0] cnt_q;

   logic [DW:0]   trial;
   logic [DW-1:0] diff;
   logic          fits;

   // The remainder is always below the divisor, so the trial value is
   // below 2*divisor. When the divisor fits, the difference therefore
   // also fits in DW bits.
   always_comb begin
      trial = {rem_q, quo_q[NW-1]};
      fits  = (trial >= {1'b0, dsr_q});
      diff  = trial[DW-1:0] - dsr_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         quo_q <= '0;
         rem_q <= '0;
         dsr_q <= '0;
         cnt_q <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            quo_q <= dividend;
            rem_q <= '0;
            dsr_q <= divisor;
            cnt_q <= CW'(NW);
            busy  <= 1'b1;
         end else if (busy) begin
            quo_q <= (quo_q << 1) | NW'(fits);
            rem_q <= fits ? diff : trial[DW-1:0];
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient = quo_q;

endmodule

// File: rtl/inv_mac1d.sv
// inv_mac1d
// Solves m*x + b = y for x, i.e. x = (y - b) / m, in signed fixed point.
// D = y - b is formed exactly, |D| is pre-shifted so the quotient lands on
// the binary point of x, and the magnitudes are divided by udiv_serial.
// The sign is applied afterwards and the result saturates to the x range.
// Division by zero skips the divider and returns the saturated value whose
// sign matches D.
// Ports:
//   clk_in    : clock
//   rst_in    : synchronous active-low reset
//   m_in      : signed slope        (IW_M.QW_M)
//   y_in      : signed target       (IW_Y.QW_Y)
//   b_in      : signed offset       (IW_B.QW_B)
//   in_valid  : operands valid
//   in_ready  : block is idle and can take operands
//   x_out     : signed solution     (IW_X.QW_X)
//   div0_out  : m was zero
//   ovf_out   : x was saturated
//   out_valid : result valid
//   out_ready : consumer takes the result
//   state     : controller state (debug)
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. The producer holds valid and its payload until that
// edge. The input side accepts only in IDLE. The output side holds
// x/flags and out_valid until out_ready is seen. The handshake edge
// returns to IDLE, and in_ready rises after that edge, which leaves a
// one-cycle bubble between jobs.
module inv_mac1d
   import inv_mac1d_pkg::*;
#(
   parameter int IW_M = 4,
   parameter int QW_M = 8,
   parameter int IW_Y = 4,
   parameter int QW_Y = 8,
   parameter int IW_B = 4,
   parameter int QW_B = 8,
   parameter int IW_X = 4,
   parameter int QW_X = 8
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic [IW_M+QW_M-1:0] m_in,
   input  logic [IW_Y+QW_Y-1:0] y_in,
   input  logic [IW_B+QW_B-1:0] b_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [IW_X+QW_X-1:0] x_out,
   output logic                 div0_out,
   output logic                 ovf_out,
   output logic                 out_valid,
   input  logic                 out_ready,
   output state_t               state
);

   localparam int WL_M = IW_M + QW_M;
   localparam int WL_Y = IW_Y + QW_Y;
   localparam int WL_B = IW_B + QW_B;
   localparam int WL_X = IW_X + QW_X;
   localparam int IW_D = fp_max(IW_Y, IW_B) + 1;
   localparam int QW_D = fp_max(QW_Y, QW_B);
   localparam int WL_D = IW_D + QW_D;
   localparam int S    = QW_X + QW_M - QW_D;
   localparam int S_U  = (S < 0) ? 0 : S;
   localparam int WN   = WL_D + S_U;
   // One extra bit so the most negative m still has a representable magnitude.
   localparam int WM   = WL_M + 1;
   localparam int CW   = fp_max(WN, WL_X) + 1;

   localparam logic [CW-1:0]   POS_LIM = (CW'(1) << (WL_X - 1)) - CW'(1);
   localparam logic [CW-1:0]   NEG_LIM = CW'(1) << (WL_X - 1);
   localparam logic [WL_X-1:0] X_MAX   = {1'b0, {(WL_X-1){1'b1}}};
   localparam logic [WL_X-1:0] X_MIN   = {1'b1, {(WL_X-1){1'b0}}};

   // If S were negative, the quotient could not carry enough fraction bits.
   if (S < 0) begin : g_bad_shift
      $error("inv_mac1d: QW_X + QW_M must be >= max(QW_Y, QW_B)");
   end

   logic [WL_D-1:0] y_al;
   logic [WL_D-1:0] b_al;
   logic [WL_D-1:0] d_val;
   logic [WL_D:0]   d_mag;
   logic [WM-1:0]   m_mag;
   logic [WN-1:0]   dividend;
   logic            d_neg;
   logic            m_neg;
   logic            m_zero;
   logic            accept;

   logic            div_start;
   logic            div_busy;
   logic            div_done;
   logic [WN-1:0]   quotient;

   logic [CW-1:0]   q_w;
   logic [WL_X-1:0] x_next;
   logic            ovf_next;

   logic            neg_q;    // sign of the result
   logic            d_neg_q;  // sign of D, selects the div-by-zero rail

   // Operand preparation uses the live inputs. The divider latches the
   // prepared values on the accept edge, so iterations start on the next edge.
   always_comb begin
      // Sign-extend to WL_D, then zero-fill the LSBs to align binary points.
      y_al   = {{(WL_D-WL_Y){y_in[WL_Y-1]}}, y_in} << (QW_D - QW_Y);
      b_al   = {{(WL_D-WL_B){b_in[WL_B-1]}}, b_in} << (QW_D - QW_B);
      d_val  = y_al - b_al;
      d_neg  = d_val[WL_D-1];
      d_mag  = d_neg ? ((WL_D+1)'(0) - {1'b1, d_val}) : {1'b0, d_val};
      m_neg  = m_in[WL_M-1];
      m_mag  = m_neg ? (WM'(0) - {1'b1, m_in}) : {1'b0, m_in};
      m_zero = (m_in == '0);
      // The extra integer bit of D keeps |D| below 2^(WL_D-1), so the top
      // bit of d_mag is always zero and truncation is safe when S == 0.
      dividend = WN'(d_mag) << S_U;
   end

   assign accept    = in_valid && in_ready;
   assign div_start = accept && !m_zero && !div_busy;

   udiv_serial #(
      .NW (WN),
      .DW (WM)
   ) u_div (
      .clk      (clk_in),
      .rst_n    (rst_in),
      .start    (div_start),
      .dividend (dividend),
      .divisor  (m_mag),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quotient)
   );

   // Apply the sign and saturate. A negative result can reach one step
   // further than a positive one (-2^(WL_X-1)).
   always_comb begin
      q_w      = CW'(quotient);
      ovf_next = 1'b0;
      x_next   = '0;
      if (neg_q) begin
         ovf_next = (q_w > NEG_LIM);
         x_next   = ovf_next ? X_MIN : (WL_X'(0) - q_w[WL_X-1:0]);
      end else begin
         ovf_next = (q_w > POS_LIM);
         x_next   = ovf_next ? X_MAX : q_w[WL_X-1:0];
      end
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         x_out     <= '0;
         div0_out  <= 1'b0;
         ovf_out   <= 1'b0;
         neg_q     <= 1'b0;
         d_neg_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  neg_q    <= d_neg ^ m_neg;
                  d_neg_q  <= d_neg;
                  in_ready <= 1'b0;
                  state    <= m_zero ? ST_DONE : ST_CALC;
               end
            end
            ST_CALC: begin
               if (div_done) begin
                  x_out     <= x_next;
                  ovf_out   <= ovf_next;
                  div0_out  <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= ST_DONE;
               end
            end
            ST_DONE: begin
               // DONE without out_valid is only reached from the m == 0
               // shortcut. The saturated result is published one edge later.
               if (!out_valid) begin
                  x_out     <= d_neg_q ? X_MIN : X_MAX;
                  div0_out  <= 1'b1;
                  ovf_out   <= 1'b0;
                  out_valid <= 1'b1;
               end else if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/inv_mac1d.md
INV_MAC1D -- requirements
Module: inv_mac1d

Interface
REQ-001 Parameters (name, default, meaning), the SHALL list:
- IW_M, 4: integer width of m.
- QW_M, 8: fractional width of m.
- IW_Y, 4: integer width of y.
- QW_Y, 8: fractional width of y.
- IW_B, 4: integer width of b.
- QW_B, 8: fractional width of b.
- IW_X, 4: integer width of x.
- QW_X, 8: fractional width of x.
REQ-002 Ports (name, direction, width, meaning), the SHALL list:
- clk_in, input, 1: the single clock.
- rst_in, input, 1: synchronous, active-low reset.
- m_in, input, IW_M+QW_M: signed slope.
- y_in, input, IW_Y+QW_Y: signed target.
- b_in, input, IW_B+QW_B: signed offset.
- in_valid, input, 1: operands valid.
- in_ready, output, 1: block can accept operands.
- x_out, output, IW_X+QW_X: signed solution.
- div0_out, output, 1: m was zero.
- ovf_out, output, 1: x was saturated.
- out_valid, output, 1: result valid.
- out_ready, input, 1: consumer accepts the result.

Function
REQ-003 Block SHALL compute x = (y - b) / m in signed fixed point, the inverse of the m*x+b MAC.
REQ-004 D = y - b SHALL be formed exactly:
- IW_D = max(IW_Y,IW_B)+1.
- QW_D = max(QW_Y,QW_B).
- Binary points aligned by zero-LSB extension.
REQ-005 S = QW_X+QW_M-QW_D; the design SHALL fail elaboration if S < 0.
REQ-006 Magnitude quotient SHALL be Q = (|D| << S) / |m|, unsigned, truncated toward zero.
- WN = IW_D+QW_D+S bits.
- Produced one bit per cycle, MSB first, restoring algorithm.
REQ-007 Sign of x SHALL be sign(D) XOR sign(m); a negative result SHALL be -Q.
REQ-008 Saturation SHALL apply:
- If positive Q > 2^(WL_X-1)-1, x = max positive and ovf_out = 1.
- If negative Q > 2^(WL_X-1), x = min negative and ovf_out = 1.
REQ-009 If m == 0, the block SHALL skip the iterations.
- x = max positive if D >= 0, else min negative.
- div0_out = 1 and ovf_out = 0.
REQ-010 FSM states SHALL be IDLE, CALC, DONE.
- IDLE -> CALC on accept with m != 0.
- IDLE -> DONE on accept with m == 0.
- CALC -> DONE after WN iterations.
- DONE -> IDLE on out_valid && out_ready.
REQ-011 in_ready SHALL equal (state == IDLE); accept SHALL be in_valid && in_ready, with operands registered on that edge.
REQ-012 Latency SHALL be fixed:
- Accept on edge 0.
- Iterations on edges 1..WN.
- x/flags registered and out_valid high after edge WN+1.
- Div-by-zero: out_valid high after edge 1.
REQ-013 Result hold rules:
- x_out, div0_out and ovf_out SHALL hold stable while out_valid && !out_ready.
- out_valid SHALL NOT drop until handshake.
REQ-014 No new operand SHALL be accepted in the handshake cycle; in_ready rises the cycle after, giving a one-cycle bubble between jobs.
REQ-015 in_valid during CALC/DONE SHALL be ignored, with no state change.
REQ-016 The most-negative m and D SHALL take magnitude without overflow (magnitude width = operand width + 1).

Reset
REQ-017 With rst_in low at a rising edge, outputs SHALL be:
- state = IDLE.
- in_ready = 1 the cycle after release.
- out_valid = 0.
- x_out = 0, div0_out = 0, ovf_out = 0.
REQ-018 Reset asserted during CALC or DONE SHALL discard the job with no out_valid pulse.

Structure
REQ-019 A shared package SHALL hold the FSM state typedef and a constant function fp_max for derived widths.
REQ-020 One sub-module SHALL exist: udiv_serial.
- Unsigned bit-serial restoring divider, parameterized on dividend/divisor widths.
- start/busy/done handshake.
- Sign, alignment, saturation and div-by-zero handling stay in inv_mac1d.

Verification (defaults; WN=21, latency 22)
REQ-021 m=0x200 (2.0), b=0x100 (1.0), y=0x500 (5.0) -> x_out=0x200 (2.0), flags 0, out_valid exactly 22 cycles after accept.
REQ-022 m=0xF80 (-0.5), b=0x000, y=0x180 (1.5) -> x_out=0xD00 (-3.0), flags 0.
REQ-023 m=0x300 (3.0), b=0, y=0x100 (1.0) -> x_out=0x055 (truncated 85/256).
REQ-024 Zero and overflow cases:
- m=0x000, y=0x100, b=0 -> x_out=0x7FF, div0_out=1, out_valid 1 cycle after accept.
- m=0x001, y=0x700, b=0 -> x_out=0x7FF, ovf_out=1.
REQ-025 Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0; then handshake -> in_ready=1 next cycle.
REQ-026 Reset mid-run: assert rst_in low at iteration 10 -> out_valid never rises, in_ready=1 after release, next job (REQ-021 operands) correct.
